nx_fifo_rd_stage: RTL and testbench

Read-side drain stage for an nx_fifo-style show-ahead FIFO. The FIFO's data is valid combinationally whenever it is not empty. This block turns the FIFO's empty/ren/rdata interface into a registered valid/ready stream with a 2-entry skid buffer.
- Delivers full throughput.
- No combinational path from out_ready to fifo_ren.
- Sits between any nx_fifo instance and a downstream pipeline consumer.

---
 rtl/nx_fifo_pkg.sv | 13 +
 rtl/nx_skid_reg.sv | 117 +++++++++++
 rtl/nx_fifo_rd_stage.sv | 54 +++++
 tb/tb_nx_fifo_rd_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/nx_fifo_pkg.sv
// Shared types and constants for the nx_fifo read-side drain stage.
package nx_fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned OCC_W      = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/nx_skid_reg.sv
// Two-entry valid/ready skid register: head drives the output, skid absorbs
// the one beat that arrives while the head is stalled.
module nx_skid_reg
    import nx_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = 128,
    parameter bit          DATA_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic [OCC_W-1:0] occ,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    occ_e             state;
    occ_e             state_nxt;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] skid;
    logic             pop;
    logic             head_ld;
    logic             head_from_skid;
    logic             skid_ld;

    // A beat offered during clear is never considered taken.
    assign pop = out_valid && out_ready && !clear;

    always_comb begin
        state_nxt      = state;
        head_ld        = 1'b0;
        head_from_skid = 1'b0;
        skid_ld        = 1'b0;
        unique case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    head_ld   = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_ld = 1'b1;
                end else if (push) begin
                    state_nxt = TWO;
                    skid_ld   = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_nxt      = ONE;
                    head_from_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (clear) begin
            state_nxt      = EMPTY;
            head_ld        = 1'b0;
            head_from_skid = 1'b0;
            skid_ld        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
        end
    end

    if (DATA_RESET) begin : g_data_rst
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                head <= '0;
                skid <= '0;
            end else if (clear) begin
                head <= '0;
                skid <= '0;
            end else begin
                if (head_ld) begin
                    head <= push_data;
                end else if (head_from_skid) begin
                    head <= skid;
                end
                if (skid_ld) begin
                    skid <= push_data;
                end
            end
        end
    end else begin : g_data_norst
        always_ff @(posedge clk) begin
            if (head_ld) begin
                head <= push_data;
            end else if (head_from_skid) begin
                head <= skid;
            end
            if (skid_ld) begin
                skid <= push_data;
            end
        end
    end

    assign out_data = head;
    assign full     = (state == TWO);
    assign occ      = state;

endmodule

// File: rtl/nx_fifo_rd_stage.sv
// Drains a show-ahead nx_fifo into a registered valid/ready stream; the read
// enable looks only at registered occupancy, never at out_ready.
module nx_fifo_rd_stage
    import nx_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = 128,
    parameter int unsigned SLOT_W     = 3,
    parameter bit          DATA_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              fifo_empty,
    input  logic [WIDTH-1:0]  fifo_rdata,
    input  logic [SLOT_W-1:0] fifo_used_slots,
    output logic              fifo_ren,
    output logic              fifo_clear,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ready,
    output logic [SLOT_W:0]   avail
);

    logic             skid_full;
    logic [OCC_W-1:0] occ;

    assign fifo_clear = clear;
    assign fifo_ren   = !rst && !clear && !fifo_empty && !skid_full;

    nx_skid_reg #(
        .WIDTH      (WIDTH),
        .DATA_RESET (DATA_RESET)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (fifo_ren),
        .push_data (fifo_rdata),
        .full      (skid_full),
        .occ       (occ),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    assign avail = (SLOT_W + 1)'(fifo_used_slots) + (SLOT_W + 1)'(occ);

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_ren && fifo_empty));

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !clear) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_nx_fifo_rd_stage.sv
// Scoreboard bench for nx_fifo_rd_stage driven by a queue-based show-ahead FIFO model.
module tb_nx_fifo_rd_stage;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned SLOT_W = 3;
    localparam int          FDEPTH = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              fifo_empty;
    logic [WIDTH-1:0]  fifo_rdata;
    logic [SLOT_W-1:0] fifo_used_slots;
    logic              fifo_ren;
    logic              fifo_clear;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic              out_ready;
    logic [SLOT_W:0]   avail;

    nx_fifo_rd_stage #(
        .WIDTH      (WIDTH),
        .SLOT_W     (SLOT_W),
        .DATA_RESET (1'b1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear),
        .fifo_empty      (fifo_empty),
        .fifo_rdata      (fifo_rdata),
        .fifo_used_slots (fifo_used_slots),
        .fifo_ren        (fifo_ren),
        .fifo_clear      (fifo_clear),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_ready       (out_ready),
        .avail           (avail)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] src_q[$];
    int               held      = 0;
    int               max_held  = 0;
    logic             ren_s     = 1'b0;
    logic             hs_s      = 1'b0;
    int               hs_count  = 0;
    int               ren_count = 0;
    int               cyc       = 0;
    int               first_hs  = -1;
    int               last_hs   = -1;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty      = (fifo_q.size() == 0);
        fifo_rdata      = (fifo_q.size() == 0) ? WIDTH'($urandom) : fifo_q[0];
        fifo_used_slots = SLOT_W'(fifo_q.size());
    endtask

    task automatic preload(input logic [WIDTH-1:0] v);
        fifo_q.push_back(v);
        exp_q.push_back(v);
        drive_fifo();
    endtask

    // Monitor: compares every observable against the model once per cycle.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            check("rst_fifo_ren", 64'(fifo_ren), 64'd0);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_out_data", 64'(out_data), 64'd0);
            ren_s      = 1'b0;
            hs_s       = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("fifo_ren", 64'(fifo_ren), 64'(!clear && fifo_q.size() != 0 && held < 2));
            check("fifo_clear", 64'(fifo_clear), 64'(clear));
            check("out_valid", 64'(out_valid), 64'(held > 0));
            check("avail", 64'(avail), 64'(fifo_q.size() + held));
            if (fifo_ren && fifo_empty) check("ren_while_empty", 64'd1, 64'd0);
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(out_data), 64'(prev_data));
            end
            hs_s = out_valid && out_ready && !clear;
            if (hs_s) begin
                if (exp_q.size() == 0) check("beat_unexpected", 64'(out_data), 64'd0);
                else                   check("beat", 64'(out_data), 64'(exp_q.pop_front()));
                hs_count++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            ren_s = fifo_ren;
            if (fifo_ren) ren_count++;
            prev_stall = out_valid && !out_ready && !clear;
            prev_data  = out_data;
        end
    end

    // One clock: apply what happened at the edge to the model, then feed the FIFO.
    task automatic step();
        @(posedge clk);
        #1;
        if (clear) begin
            fifo_q.delete();
            exp_q.delete();
            src_q.delete();
            held = 0;
        end else begin
            held = held + int'(ren_s) - int'(hs_s);
            if (ren_s) void'(fifo_q.pop_front());
        end
        if (held > max_held) max_held = held;
        if (src_q.size() > 0 && fifo_q.size() < FDEPTH) begin
            fifo_q.push_back(src_q[0]);
            exp_q.push_back(src_q.pop_front());
        end
        drive_fifo();
    endtask

    task automatic drain();
        int i;
        out_ready = 1'b1;
        for (i = 0; i < 200 && !(held == 0 && fifo_q.size() == 0 && src_q.size() == 0); i++) step();
        check("drain_done", 64'(held == 0 && fifo_q.size() == 0 && src_q.size() == 0), 64'd1);
        check("drain_exp_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int hs0;
        int r0;
        int rel;
        rst       = 1'b1;
        clear     = 1'b0;
        out_ready = 1'b1;
        drive_fifo();

        // Reset held with three beats waiting in the FIFO.
        preload(32'hA);
        preload(32'hB);
        preload(32'hC);
        repeat (3) step();
        hs0 = hs_count; first_hs = -1; rel = cyc;
        rst = 1'b0;
        drain();
        check("reset_beats", 64'(hs_count - hs0), 64'd3);
        check("reset_latency", 64'(first_hs - rel), 64'd2);
        check("reset_consec", 64'(last_hs - first_hs), 64'd2);

        // Full-rate streaming.
        hs0 = hs_count; first_hs = -1; max_held = 0;
        for (int i = 0; i < 16; i++) src_q.push_back(WIDTH'(32'h100 + i));
        drain();
        check("stream_beats", 64'(hs_count - hs0), 64'd16);
        check("stream_consec", 64'(last_hs - first_hs), 64'd15);
        check("stream_occ_max", 64'(max_held), 64'd1);

        // Backpressure: at most two beats absorbed.
        for (int i = 0; i < 5; i++) preload(WIDTH'(32'h200 + i));
        out_ready = 1'b0;
        r0 = ren_count; hs0 = hs_count;
        repeat (10) step();
        check("bp_ren_pulses", 64'(ren_count - r0), 64'd2);
        drain();
        check("bp_beats", 64'(hs_count - hs0), 64'd5);

        // Ready toggling every cycle.
        hs0 = hs_count;
        for (int i = 0; i < 8; i++) src_q.push_back(WIDTH'(32'h300 + i));
        repeat (24) begin
            out_ready = !out_ready;
            step();
        end
        drain();
        check("toggle_beats", 64'(hs_count - hs0), 64'd8);

        // Clear with both skid entries and three FIFO entries occupied.
        for (int i = 0; i < 5; i++) preload(WIDTH'(32'h400 + i));
        out_ready = 1'b0;
        repeat (3) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        drain();

        // Asynchronous reset mid-stream.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) src_q.push_back(WIDTH'(32'h500 + i));
        repeat (4) step();
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_data", 64'(out_data), 64'd0);
        check("async_rst_ren", 64'(fifo_ren), 64'd0);
        repeat (held) void'(exp_q.pop_front());
        held = 0;
        repeat (2) step();
        rst = 1'b0;
        drain();

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            clear     = ($urandom_range(0, 59) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0 && src_q.size() < 4) src_q.push_back(WIDTH'($urandom));
            step();
        end
        clear = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
